// File: rtl/module_control_banco_registros.sv
// Periodic write scheduler for the PIPO register bank: one entry per period, single or continuous sweep.
// Optional build macro CTRL_PAUSE_EN adds a pause input that freezes the period counter while waiting.
module module_control_banco_registros #(
    parameter int unsigned PERIOD_CYCLES = 20000000,
    parameter int unsigned CNT_W         = 25,
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned ADDR_W        = 3,
    parameter int unsigned DATA_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuo,
`ifdef CTRL_PAUSE_EN
    input  logic              pause,
`endif
    input  logic [DATA_W-1:0] data_in,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              sweep_done
);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD_CYCLES - 2);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [ADDR_W-1:0] idx, idx_nx;
    logic              mode, mode_nx;
    logic              load;
    logic              hold;

`ifdef CTRL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            mode  <= mode_nx;
        end
    end

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        mode_nx  = mode;
        load     = 1'b0;
        if (stop) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !busy) begin
                        state_nx = WAIT;
                        cnt_nx   = '0;
                        idx_nx   = '0;
                        mode_nx  = continuo;
                    end
                end
                WAIT: begin
                    if (!hold) begin
                        if (cnt == CNT_LAST) begin
                            load     = 1'b1;
                            state_nx = WRITE;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    cnt_nx = '0;
                    if (idx != IDX_LAST) begin
                        idx_nx   = idx + 1'b1;
                        state_nx = WAIT;
                    end else if (mode) begin
                        idx_nx   = '0;
                        state_nx = WAIT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // NOTE: outputs are registered images of the FSM one cycle later, which places the
    // first write PERIOD_CYCLES after start; stop clears them directly so it acts next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we         <= 1'b0;
            addr       <= '0;
            data_out   <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            if (load) begin
                data_out <= data_in;
            end
            if (stop) begin
                we         <= 1'b0;
                addr       <= '0;
                busy       <= 1'b0;
                sweep_done <= 1'b0;
            end else begin
                we         <= (state == WRITE);
                addr       <= idx;
                busy       <= (state != IDLE);
                sweep_done <= (state == WRITE) && (idx == IDX_LAST);
            end
        end
    end

endmodule

// File: tb/tb_module_control_banco_registros.sv
// Directed bench for module_control_banco_registros with PERIOD_CYCLES=4, NUM_REGS=4.
// Edge 0 is the clock edge that samples the start pulse; outputs are sampled 1 ns after each edge.
module tb_module_control_banco_registros;

    localparam int P = 4;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuo = 1'b0;
`ifdef CTRL_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [7:0] data_in = 8'h00;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data_out;
    logic       busy;
    logic       sweep_done;

    int errors = 0;
    int checks = 0;

    module_control_banco_registros #(
        .PERIOD_CYCLES(P), .CNT_W(3), .NUM_REGS(N), .ADDR_W(2), .DATA_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuo(continuo),
`ifdef CTRL_PAUSE_EN
        .pause(pause),
`endif
        .data_in(data_in), .we(we), .addr(addr), .data_out(data_out),
        .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef CTRL_PAUSE_EN
        pause = 1'b0;
`endif
        step;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Start pulse sampled at the next rising edge, which becomes edge 0.
    task automatic start_pulse;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        checks++;
        if ({we, addr, data_out, busy, sweep_done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_values: got we=%b addr=%0d data=%h busy=%b done=%b, want all 0",
                     we, addr, data_out, busy, sweep_done);
        end
        start = 1'b1;
        step;
        step;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got busy=%b we=%b, want 0 0", busy, we);
        end
    endtask

    task automatic test_single_sweep;
        logic       exp_we;
        logic [1:0] exp_addr;
        do_reset;
        continuo = 1'b0;
        data_in  = 8'h3C;
        start_pulse;
        for (int e = 1; e <= 20; e++) begin
            step;
            exp_we   = (e % P == 0) && (e <= 16);
            exp_addr = 2'((e / P) - 1);
            checks++;
            if (we !== exp_we) begin
                errors++;
                $display("FAIL single_we edge %0d: got %b want %b", e, we, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (addr !== exp_addr || data_out !== 8'h3C) begin
                    errors++;
                    $display("FAIL single_write edge %0d: got addr=%0d data=%h want addr=%0d data=3c",
                             e, addr, data_out, exp_addr);
                end
            end
            checks++;
            if (sweep_done !== (e == 16)) begin
                errors++;
                $display("FAIL single_done edge %0d: got %b want %b", e, sweep_done, e == 16);
            end
            checks++;
            if (busy !== (e <= 16)) begin
                errors++;
                $display("FAIL single_busy edge %0d: got %b want %b", e, busy, e <= 16);
            end
        end
        checks++;
        if (addr !== 2'd3) begin
            errors++;
            $display("FAIL single_addr_hold: got %0d want 3", addr);
        end
    endtask

    task automatic test_continuous;
        logic       exp_we;
        logic [1:0] exp_addr;
        do_reset;
        continuo = 1'b1;
        data_in  = 8'hA5;
        start_pulse;
        continuo = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            step;
            exp_we   = (e % P == 0);
            exp_addr = 2'(((e / P) - 1) % N);
            checks++;
            if (we !== exp_we || busy !== 1'b1) begin
                errors++;
                $display("FAIL cont_we edge %0d: got we=%b busy=%b want we=%b busy=1", e, we, busy, exp_we);
            end
            if (exp_we) begin
                checks++;
                if (addr !== exp_addr || data_out !== 8'hA5) begin
                    errors++;
                    $display("FAIL cont_write edge %0d: got addr=%0d data=%h want addr=%0d data=a5",
                             e, addr, data_out, exp_addr);
                end
            end
            checks++;
            if (sweep_done !== (e == 16 || e == 32)) begin
                errors++;
                $display("FAIL cont_done edge %0d: got %b want %b", e, sweep_done, e == 16 || e == 32);
            end
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
    endtask

    task automatic test_stop;
        do_reset;
        continuo = 1'b1;
        data_in  = 8'h11;
        start_pulse;
        repeat (9) step;
        stop = 1'b1;
        step;
        stop = 1'b0;
        checks++;
        if (we !== 1'b0 || addr !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_clear: got we=%b addr=%0d busy=%b want 0 0 0", we, addr, busy);
        end
        for (int e = 11; e <= 22; e++) begin
            step;
            checks++;
            if (we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stop_idle edge %0d: got we=%b busy=%b want 0 0", e, we, busy);
            end
        end
        start = 1'b1;
        stop  = 1'b1;
        step;
        start = 1'b0;
        stop  = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step;
            checks++;
            if (we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL start_stop edge %0d: got we=%b busy=%b want 0 0", e, we, busy);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        continuo = 1'b1;
        data_in  = 8'h5A;
        start_pulse;
        repeat (6) step;
        checks++;
        if (busy !== 1'b1 || addr !== 2'd1) begin
            errors++;
            $display("FAIL async_pre: got busy=%b addr=%0d want 1 1", busy, addr);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || busy !== 1'b0 || addr !== 2'd0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got we=%b busy=%b addr=%0d data=%h want 0 0 0 00",
                     we, busy, addr, data_out);
        end
        @(negedge clk);
        rst = 1'b1;
        data_in = 8'hC3;
        start_pulse;
        for (int e = 1; e <= P; e++) begin
            step;
            checks++;
            if (we !== (e == P)) begin
                errors++;
                $display("FAIL async_restart_we edge %0d: got %b want %b", e, we, e == P);
            end
        end
        checks++;
        if (addr !== 2'd0 || data_out !== 8'hC3) begin
            errors++;
            $display("FAIL async_restart_write: got addr=%0d data=%h want 0 c3", addr, data_out);
        end
        stop = 1'b1;
        step;
        stop = 1'b0;
    endtask

    task automatic test_start_while_busy;
        logic exp_we;
        do_reset;
        continuo = 1'b0;
        data_in  = 8'h77;
        start_pulse;
        for (int e = 1; e <= 19; e++) begin
            start    = (e == 2 || e == 5 || e == 10);
            continuo = 1'b1;
            step;
            start = 1'b0;
            exp_we = (e % P == 0) && (e <= 16);
            checks++;
            if (we !== exp_we || busy !== (e <= 16)) begin
                errors++;
                $display("FAIL busy_start edge %0d: got we=%b busy=%b want %b %b",
                         e, we, busy, exp_we, e <= 16);
            end
            if (exp_we) begin
                checks++;
                if (addr !== 2'((e / P) - 1)) begin
                    errors++;
                    $display("FAIL busy_start_addr edge %0d: got %0d want %0d", e, addr, (e / P) - 1);
                end
            end
        end
        continuo = 1'b0;
    endtask

`ifdef CTRL_PAUSE_EN
    task automatic test_pause;
        logic exp_we;
        do_reset;
        continuo = 1'b1;
        data_in  = 8'h99;
        start_pulse;
        for (int e = 1; e <= 16; e++) begin
            pause = (e >= 1 && e <= 3);
            step;
            exp_we = (e == 7 || e == 11 || e == 15);
            checks++;
            if (we !== exp_we || busy !== 1'b1) begin
                errors++;
                $display("FAIL pause edge %0d: got we=%b busy=%b want %b 1", e, we, busy, exp_we);
            end
        end
        pause = 1'b0;
        stop  = 1'b1;
        step;
        stop  = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_single_sweep;
        test_continuous;
        test_stop;
        test_async_reset;
        test_start_while_busy;
`ifdef CTRL_PAUSE_EN
        test_pause;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
